// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounced buttons drive an edit FSM that
// shadows the live time, lets the user adjust hour/minute/second with
// wrap-around, blinks the selected field and commits with a load pulse.
module clock_set_ctrl #(
   parameter int unsigned DEB_CYC     = 2000000,
   parameter int unsigned BLINK_CYC   = 25000000,
   parameter int unsigned TIMEOUT_CYC = 1000000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key,
   input  logic [7:0] cur_hour,
   input  logic [7:0] cur_min,
   input  logic [7:0] cur_sec,
   output logic       editing,
   output logic       load,
   output logic [7:0] set_hour,
   output logic [7:0] set_min,
   output logic [7:0] set_sec,
   output logic [7:0] digit_blank
);

   localparam int unsigned NKEY    = 5;
   localparam int unsigned DEB_W   = $clog2(DEB_CYC + 1);
   localparam int unsigned BLINK_W = $clog2(BLINK_CYC + 1);
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);

   localparam logic [2:0] RUN    = 3'd0;
   localparam logic [2:0] EDIT_H = 3'd1;
   localparam logic [2:0] EDIT_M = 3'd2;
   localparam logic [2:0] EDIT_S = 3'd3;
   localparam logic [2:0] COMMIT = 3'd4;

   localparam logic [7:0] MASK_H = 8'b0000_0011;
   localparam logic [7:0] MASK_M = 8'b0001_1000;
   localparam logic [7:0] MASK_S = 8'b1100_0000;

   logic [NKEY-1:0]  sync1, sync2;
   logic [NKEY-1:0]  deb, deb_d, armed;
   logic [DEB_W-1:0] deb_cnt [NKEY];
   logic [NKEY-1:0]  press;

   logic ev_mode, ev_left, ev_right, ev_up, ev_down;

   logic [2:0]         state, state_nxt;
   logic [7:0]         hour_nxt, min_nxt, sec_nxt;
   logic               idle_clr, blink_clr;
   logic [TO_W-1:0]    idle_cnt, idle_nxt;
   logic [BLINK_W-1:0] blink_cnt, blink_nxt;
   logic               phase, phase_nxt;
   logic               edit_nxt;
   logic [7:0]         blank_nxt;

   // Two-flop synchronizer for the raw buttons
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
      end
   end

   // Debouncer; a key is armed only after it has been seen released for
   // DEB_CYC cycles, so a button held through reset never fires
   always_ff @(posedge clk) begin
      if (rst) begin
         deb   <= '0;
         deb_d <= '0;
         armed <= '0;
         for (int i = 0; i < NKEY; i++) deb_cnt[i] <= '0;
      end else begin
         deb_d <= deb;
         for (int i = 0; i < NKEY; i++) begin
            if (!armed[i]) begin
               if (sync2[i]) begin
                  deb_cnt[i] <= '0;
               end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
                  armed[i]   <= 1'b1;
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
               end
            end else if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   // Press events on debounced rising edges, reduced to the single winner
   assign press    = deb & ~deb_d;
   assign ev_mode  = press[0];
   assign ev_left  = press[1] & ~press[0];
   assign ev_right = press[2] & ~(|press[1:0]);
   assign ev_up    = press[3] & ~(|press[2:0]);
   assign ev_down  = press[4] & ~(|press[3:0]);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next state, shadow arithmetic, idle/blink counters and output values
   always_comb begin
      state_nxt = state;
      hour_nxt  = set_hour;
      min_nxt   = set_min;
      sec_nxt   = set_sec;
      idle_clr  = 1'b0;
      blink_clr = 1'b0;
      idle_nxt  = '0;
      blink_nxt = '0;
      phase_nxt = 1'b0;
      blank_nxt = '0;

      case (state)
         RUN: begin
            if (ev_mode) begin
               state_nxt = EDIT_H;
               hour_nxt  = (cur_hour < 8'd24) ? cur_hour : 8'd0;
               min_nxt   = (cur_min  < 8'd60) ? cur_min  : 8'd0;
               sec_nxt   = (cur_sec  < 8'd60) ? cur_sec  : 8'd0;
               idle_clr  = 1'b1;
               blink_clr = 1'b1;
            end
         end
         EDIT_H, EDIT_M, EDIT_S: begin
            if (ev_mode) begin
               state_nxt = COMMIT;
               idle_clr  = 1'b1;
            end else if (ev_right) begin
               state_nxt = (state == EDIT_H) ? EDIT_M :
                           (state == EDIT_M) ? EDIT_S : EDIT_H;
               idle_clr  = 1'b1;
               blink_clr = 1'b1;
            end else if (ev_left) begin
               state_nxt = (state == EDIT_H) ? EDIT_S :
                           (state == EDIT_S) ? EDIT_M : EDIT_H;
               idle_clr  = 1'b1;
               blink_clr = 1'b1;
            end else if (ev_up || ev_down) begin
               idle_clr  = 1'b1;
               blink_clr = 1'b1;
               case (state)
                  EDIT_H: begin
                     if (ev_up) hour_nxt = (set_hour >= 8'd23) ? 8'd0 : set_hour + 8'd1;
                     else       hour_nxt = (set_hour == 8'd0) ? 8'd23 : set_hour - 8'd1;
                  end
                  EDIT_M: begin
                     if (ev_up) min_nxt = (set_min >= 8'd59) ? 8'd0 : set_min + 8'd1;
                     else       min_nxt = (set_min == 8'd0) ? 8'd59 : set_min - 8'd1;
                  end
                  default: begin
                     if (ev_up) sec_nxt = (set_sec >= 8'd59) ? 8'd0 : set_sec + 8'd1;
                     else       sec_nxt = (set_sec == 8'd0) ? 8'd59 : set_sec - 8'd1;
                  end
               endcase
            end else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
               state_nxt = RUN;
            end
         end
         COMMIT:  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase

      edit_nxt = (state_nxt == EDIT_H) || (state_nxt == EDIT_M) ||
                 (state_nxt == EDIT_S);

      if (edit_nxt && !idle_clr) idle_nxt = idle_cnt + TO_W'(1);

      if (edit_nxt && !blink_clr) begin
         if (blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
            blink_nxt = '0;
            phase_nxt = ~phase;
         end else begin
            blink_nxt = blink_cnt + BLINK_W'(1);
            phase_nxt = phase;
         end
      end

      if (phase_nxt) begin
         case (state_nxt)
            EDIT_H:  blank_nxt = MASK_H;
            EDIT_M:  blank_nxt = MASK_M;
            EDIT_S:  blank_nxt = MASK_S;
            default: blank_nxt = '0;
         endcase
      end
   end

   // Registered outputs and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         editing     <= 1'b0;
         load        <= 1'b0;
         set_hour    <= '0;
         set_min     <= '0;
         set_sec     <= '0;
         digit_blank <= '0;
         idle_cnt    <= '0;
         blink_cnt   <= '0;
         phase       <= 1'b0;
      end else begin
         editing     <= (state_nxt != RUN);
         load        <= (state_nxt == COMMIT);
         set_hour    <= hour_nxt;
         set_min     <= min_nxt;
         set_sec     <= sec_nxt;
         digit_blank <= blank_nxt;
         idle_cnt    <= idle_nxt;
         blink_cnt   <= blink_nxt;
         phase       <= phase_nxt;
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/blink/timeout.
module tb_clock_set_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] key;
   logic [7:0] cur_hour, cur_min, cur_sec;
   logic       editing, load;
   logic [7:0] set_hour, set_min, set_sec, digit_blank;

   int n_cmp  = 0;
   int n_fail = 0;
   int load_cnt = 0;
   logic [7:0] ld_h, ld_m, ld_s;

   clock_set_ctrl #(.DEB_CYC(4), .BLINK_CYC(8), .TIMEOUT_CYC(200)) dut (
      .clk(clk), .rst(rst), .key(key),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .editing(editing), .load(load),
      .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
      .digit_blank(digit_blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Load pulse monitor: counts pulses and captures the values presented
   always @(posedge clk) begin
      #1;
      if (load === 1'b1) begin
         load_cnt++;
         ld_h = set_hour;
         ld_m = set_min;
         ld_s = set_sec;
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int idx);
      key[idx] = 1'b1;
      tick(8);
      key[idx] = 1'b0;
      tick(8);
   endtask

   task automatic enter_edit(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      int k;
      cur_hour = h; cur_min = m; cur_sec = s;
      k = 0;
      key[0] = 1'b1;
      while (editing !== 1'b1 && k < 20) begin
         tick(1);
         k++;
      end
      n_cmp++;
      if (editing !== 1'b1) begin
         n_fail++;
         $display("FAIL enter_edit: editing=%b expected 1 within 20 cycles", editing);
      end
      key[0] = 1'b0;
      tick(8);
   endtask

   task automatic test_reset;
      rst = 1'b1; key = '0;
      cur_hour = 8'd0; cur_min = 8'd0; cur_sec = 8'd0;
      tick(3);
      n_cmp++;
      if ({editing, load, set_hour, set_min, set_sec, digit_blank} !== 34'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {editing, load, set_hour, set_min, set_sec, digit_blank});
      end
      rst = 1'b0;
      tick(10);
   endtask

   task automatic test_run_ignore;
      cur_hour = 8'd12; cur_min = 8'd34; cur_sec = 8'd56;
      press(3); press(2); press(4); press(1);
      n_cmp++;
      if (editing !== 1'b0) begin
         n_fail++; $display("FAIL run_ignore_editing: got %b expected 0", editing);
      end
      n_cmp++;
      if ({set_hour, set_min, set_sec, digit_blank} !== 32'd0) begin
         n_fail++;
         $display("FAIL run_ignore_shadow: got %h expected 0",
                  {set_hour, set_min, set_sec, digit_blank});
      end
   endtask

   task automatic test_enter_blink;
      int k;
      logic [7:0] exp;
      cur_hour = 8'd12; cur_min = 8'd34; cur_sec = 8'd56;
      k = 0;
      key[0] = 1'b1;
      while (editing !== 1'b1 && k < 20) begin
         tick(1);
         k++;
      end
      n_cmp++;
      if (editing !== 1'b1) begin
         n_fail++; $display("FAIL blink_enter: editing=%b expected 1", editing);
      end
      n_cmp++;
      if ({set_hour, set_min, set_sec} !== {8'd12, 8'd34, 8'd56}) begin
         n_fail++;
         $display("FAIL blink_capture: got %0d:%0d:%0d expected 12:34:56",
                  set_hour, set_min, set_sec);
      end
      for (int i = 0; i < 16; i++) begin
         exp = (i < 8) ? 8'h00 : 8'h03;
         n_cmp++;
         if (digit_blank !== exp) begin
            n_fail++;
            $display("FAIL blink_cycle%0d: digit_blank=%b expected %b", i, digit_blank, exp);
         end
         tick(1);
      end
      key[0] = 1'b0;
      tick(8);
      press(0);
   endtask

   task automatic test_wrap;
      enter_edit(8'd23, 8'd59, 8'd0);
      press(3);
      n_cmp++;
      if (set_hour !== 8'd0) begin
         n_fail++; $display("FAIL hour_up_wrap: got %0d expected 0", set_hour);
      end
      press(4);
      n_cmp++;
      if (set_hour !== 8'd23) begin
         n_fail++; $display("FAIL hour_down_wrap: got %0d expected 23", set_hour);
      end
      press(2);
      press(3);
      n_cmp++;
      if (set_min !== 8'd0) begin
         n_fail++; $display("FAIL min_up_wrap: got %0d expected 0", set_min);
      end
      n_cmp++;
      if (set_hour !== 8'd23) begin
         n_fail++; $display("FAIL min_edit_hour_kept: got %0d expected 23", set_hour);
      end
      press(0);
   endtask

   task automatic test_commit;
      int lc;
      enter_edit(8'd1, 8'd2, 8'd0);
      press(2); press(2); press(4);
      n_cmp++;
      if (set_sec !== 8'd59) begin
         n_fail++; $display("FAIL sec_down_wrap: got %0d expected 59", set_sec);
      end
      lc = load_cnt;
      press(0);
      n_cmp++;
      if (load_cnt !== lc + 1) begin
         n_fail++; $display("FAIL commit_load_count: got %0d expected %0d", load_cnt - lc, 1);
      end
      n_cmp++;
      if ({ld_h, ld_m, ld_s} !== {8'd1, 8'd2, 8'd59}) begin
         n_fail++;
         $display("FAIL commit_values: got %0d:%0d:%0d expected 1:2:59", ld_h, ld_m, ld_s);
      end
      n_cmp++;
      if (editing !== 1'b0 || load !== 1'b0) begin
         n_fail++;
         $display("FAIL commit_exit: editing=%b load=%b expected 0 0", editing, load);
      end
   endtask

   task automatic test_left;
      enter_edit(8'd5, 8'd10, 8'd20);
      press(1); press(3);
      n_cmp++;
      if ({set_hour, set_min, set_sec} !== {8'd5, 8'd10, 8'd21}) begin
         n_fail++;
         $display("FAIL left_to_sec: got %0d:%0d:%0d expected 5:10:21", set_hour, set_min, set_sec);
      end
      press(1); press(3);
      n_cmp++;
      if ({set_hour, set_min, set_sec} !== {8'd5, 8'd11, 8'd21}) begin
         n_fail++;
         $display("FAIL left_to_min: got %0d:%0d:%0d expected 5:11:21", set_hour, set_min, set_sec);
      end
      press(1); press(3);
      n_cmp++;
      if ({set_hour, set_min, set_sec} !== {8'd6, 8'd11, 8'd21}) begin
         n_fail++;
         $display("FAIL left_to_hour: got %0d:%0d:%0d expected 6:11:21", set_hour, set_min, set_sec);
      end
      press(0);
   endtask

   task automatic test_bounce_priority;
      int lc;
      enter_edit(8'd7, 8'd8, 8'd9);
      for (int i = 0; i < 5; i++) begin
         key[3] = 1'b1; tick(2);
         key[3] = 1'b0; tick(3);
      end
      key[3] = 1'b1; tick(3);
      key[3] = 1'b0; tick(10);
      n_cmp++;
      if ({set_hour, set_min, set_sec} !== {8'd7, 8'd8, 8'd9}) begin
         n_fail++;
         $display("FAIL bounce_ignored: got %0d:%0d:%0d expected 7:8:9", set_hour, set_min, set_sec);
      end
      lc = load_cnt;
      key[0] = 1'b1; key[3] = 1'b1;
      tick(8);
      key[0] = 1'b0; key[3] = 1'b0;
      tick(8);
      n_cmp++;
      if (load_cnt !== lc + 1) begin
         n_fail++; $display("FAIL prio_load_count: got %0d expected 1", load_cnt - lc);
      end
      n_cmp++;
      if (ld_h !== 8'd7) begin
         n_fail++; $display("FAIL prio_up_discarded: got hour %0d expected 7", ld_h);
      end
      n_cmp++;
      if (editing !== 1'b0) begin
         n_fail++; $display("FAIL prio_exit: editing=%b expected 0", editing);
      end
   endtask

   task automatic test_timeout;
      int lc;
      int k;
      lc = load_cnt;
      cur_hour = 8'd3; cur_min = 8'd4; cur_sec = 8'd5;
      k = 0;
      key[0] = 1'b1;
      while (editing !== 1'b1 && k < 20) begin
         tick(1);
         k++;
      end
      n_cmp++;
      if (editing !== 1'b1) begin
         n_fail++; $display("FAIL timeout_enter: editing=%b expected 1", editing);
      end
      key[0] = 1'b0;
      tick(150);
      n_cmp++;
      if (editing !== 1'b1) begin
         n_fail++; $display("FAIL timeout_still_editing: got %b expected 1", editing);
      end
      tick(70);
      n_cmp++;
      if (editing !== 1'b0) begin
         n_fail++; $display("FAIL timeout_abort: editing=%b expected 0", editing);
      end
      n_cmp++;
      if (load_cnt !== lc) begin
         n_fail++; $display("FAIL timeout_no_load: got %0d pulses expected 0", load_cnt - lc);
      end
   endtask

   task automatic test_reset_mid_edit;
      int lc;
      lc = load_cnt;
      enter_edit(8'd9, 8'd9, 8'd9);
      press(1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      n_cmp++;
      if ({editing, load, set_hour, set_min, set_sec, digit_blank} !== 34'd0) begin
         n_fail++;
         $display("FAIL rst_mid_edit: got %h expected 0",
                  {editing, load, set_hour, set_min, set_sec, digit_blank});
      end
      tick(10);
      n_cmp++;
      if (load_cnt !== lc) begin
         n_fail++; $display("FAIL rst_mid_edit_no_load: got %0d pulses expected 0", load_cnt - lc);
      end
   endtask

   task automatic test_hold_through_reset;
      key[0] = 1'b1;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(20);
      n_cmp++;
      if (editing !== 1'b0) begin
         n_fail++; $display("FAIL held_key_no_event: editing=%b expected 0", editing);
      end
      key[0] = 1'b0;
      tick(10);
      enter_edit(8'd22, 8'd33, 8'd44);
      n_cmp++;
      if ({set_hour, set_min, set_sec} !== {8'd22, 8'd33, 8'd44}) begin
         n_fail++;
         $display("FAIL held_key_rearm: got %0d:%0d:%0d expected 22:33:44", set_hour, set_min, set_sec);
      end
      press(0);
   endtask

   initial begin
      test_reset();
      test_run_ignore();
      test_enter_blink();
      test_wrap();
      test_commit();
      test_left();
      test_bounce_priority();
      test_timeout();
      test_reset_mid_edit();
      test_hold_through_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
